jamma_input_scanner: RTL and testbench
======================================

# jamma_input_scanner

Parametrised JAMMA control-panel scanner for the arcade ports. It drives the external player-select line(s) round-robin and waits a settle time before sampling the shared 8-bit JAMMA joystick bus. Each player's inputs are debounced and coin inputs are synchronised and pulse-stretched. It also generates the core's power-on reset delay. It sits between the board pins (JJOY, JCOIN, JSELECT) and the game core's I_JOYSTICK_x / I_PLAYER / I_COIN / reset inputs, and replaces the per-clock toggle split in each top level.

## Interface
Parameters:
- NUM_PLAYERS, 2: players multiplexed on the bus; legal 2..4.
- JOY_W, 8: bus width (6 joystick/fire + start + spare).
- SETTLE_CYCLES, 4: cycles from a select change to the sample; minimum 3, which covers the 2-flop synchroniser.
- DEB_COUNT, 4: consecutive differing samples needed to flip a debounced bit; legal 1..255; 1 means no debounce.
- COIN_HOLD, 1024: minimum low time of a stretched coin output, in cycles.
- RST_DELAY, 256: cycles core_reset stays high after reset release.

Ports:
- pclk in 1: pixel/system clock; the only clock.
- reset_n in 1: asynchronous, active-low reset.
- jjoy in JOY_W: shared JAMMA bus, active-low, asynchronous.
- jcoin_n in NUM_PLAYERS: coin switches, active-low, asynchronous.
- jselect out max(1,$clog2(NUM_PLAYERS)): player currently addressed.
- joy_n out NUM_PLAYERS*JOY_W: debounced inputs, active-low; player p occupies [p*JOY_W +: JOY_W].
- coin_n out NUM_PLAYERS: synchronised, stretched coin inputs, active-low.
- scan_done out 1: one-cycle strobe when the last player's sample is taken.
- core_reset out 1: active-high reset for the game core.

## Operation
Reset values: jselect=0, joy_n all ones, coin_n all ones, scan_done=0, core_reset=1. All counters and the state register clear to 0, and the FSM enters SETTLE with player 0.

jjoy and jcoin_n each pass through a 2-flop synchroniser, giving sync_joy and sync_coin.

FSM:
- SETTLE: the settle counter increments from 0. When it reaches SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle): feed sync_joy to the debouncer of player jselect. If jselect==NUM_PLAYERS-1, pulse scan_done. Next cycle, jselect becomes (jselect+1) mod NUM_PLAYERS, the settle counter clears, and the FSM returns to SETTLE.

Debounce, per player and per bit, with an 8-bit counter:
- sample == current joy_n bit: clear the counter.
- sample differs and counter == DEB_COUNT-1: flip the bit and clear the counter.
- Otherwise: increment the counter.
- Counters advance only in that player's SAMPLE cycle.

Coin stretch, per player:
- A falling edge of sync_coin forces coin_n low and loads a hold counter with COIN_HOLD-1.
- coin_n returns high once the hold counter reaches 0 and sync_coin is high.
- A new falling edge during hold reloads the counter.

Reset delay: a counter runs from reset release. core_reset deasserts at the edge where the count reaches RST_DELAY-1, then holds 0 until reset_n asserts again.

Reset mid-scan: the asynchronous clear aborts at once, with no partial update. A sample in flight is discarded.

## Timing
- Slot length is SETTLE_CYCLES+1 cycles. Full scan period is NUM_PLAYERS*(SETTLE_CYCLES+1).
- Pin-to-joy_n latency with DEB_COUNT=1: the change must reach the synchroniser at least 2 cycles before SAMPLE, and joy_n updates 1 cycle after SAMPLE. With DEB_COUNT=k, the update follows the k-th consecutive differing sample.
- coin_n goes low 3 cycles after a jcoin_n falling edge at the pin (2 sync + 1 edge register).
- scan_done is coincident with the last player's SAMPLE cycle.
- joy_n changes only on the cycle after a SAMPLE cycle.

## Structure
- A shared package jamma_pkg holds the FSM state enum (SETTLE, SAMPLE) and the default parameter constants, so each arcade top can override them.
- One sub-module, jamma_debounce_bit (counter plus output bit, enable and sample inputs), is instantiated NUM_PLAYERS*JOY_W times.
- Synchronisers reuse the existing synchro cell.

## Test plan
Default settings for the scenarios are NUM_PLAYERS=2, SETTLE_CYCLES=4, DEB_COUNT=2 and RST_DELAY=16 (COIN_HOLD=8 where stated). Each line is stimulus -> required response.

- Release reset_n -> jselect toggles every 5 cycles, scan_done every 10 cycles, and core_reset falls exactly 16 cycles after release.
- Hold jjoy=8'hFE while jselect=0 and 8'hFF while jselect=1 -> joy_n[7:0]=FE after the second player-0 sample, and joy_n[15:8] stays FF.
- A glitch on bit 0 present for one player-0 sample only -> joy_n[0] stays 1.
- With DEB_COUNT=1 -> joy_n updates after the first differing sample.
- jcoin_n[1] low for 2 cycles (COIN_HOLD=8) -> coin_n[1] goes low 3 cycles after the pin edge and stays low exactly 8 cycles.
- Assert reset_n low mid-SETTLE with joy_n=FE -> all outputs take their reset values in the same cycle, and scanning resumes at player 0 after release.
- NUM_PLAYERS=4 -> jselect sequence 0,1,2,3,0 and joy_n width 32, with each player's word isolated from the others.

Source files
------------

// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA control-panel scanner: scan FSM states,
// default parameter constants and a counter-width helper.
package jamma_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        SAMPLE = 1'b1
    } scan_state_t;

    localparam int DEF_NUM_PLAYERS   = 2;
    localparam int DEF_JOY_W         = 8;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_DEB_COUNT     = 4;
    localparam int DEF_COIN_HOLD     = 1024;
    localparam int DEF_RST_DELAY     = 256;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jamma_debounce_bit.sv
// One debounced active-low input bit: the output flips only after DEB_COUNT
// consecutive enabled samples that disagree with it.
module jamma_debounce_bit #(
    parameter int DEB_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sample,
    output logic out_n
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_COUNT - 1);

    logic [7:0] cnt;

    // Count disagreeing samples; an agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            out_n <= 1'b1;
        end else if (en) begin
            if (sample == out_n) begin
                cnt <= 8'd0;
            end else if (cnt == CNT_LAST) begin
                out_n <= ~out_n;
                cnt   <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/jamma_input_scanner.sv
// JAMMA control-panel scanner: round-robin player select with settle time,
// per-player debounced joystick words, stretched coin inputs and the game
// core's power-on reset delay.
module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int NUM_PLAYERS   = DEF_NUM_PLAYERS,
    parameter int JOY_W         = DEF_JOY_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DEB_COUNT     = DEF_DEB_COUNT,
    parameter int COIN_HOLD     = DEF_COIN_HOLD,
    parameter int RST_DELAY     = DEF_RST_DELAY,
    localparam int SEL_W        = cnt_width(NUM_PLAYERS)
) (
    input  logic                         pclk,
    input  logic                         reset_n,
    input  logic [JOY_W-1:0]             jjoy,
    input  logic [NUM_PLAYERS-1:0]       jcoin_n,
    output logic [SEL_W-1:0]             jselect,
    output logic [NUM_PLAYERS*JOY_W-1:0] joy_n,
    output logic [NUM_PLAYERS-1:0]       coin_n,
    output logic                         scan_done,
    output logic                         core_reset
);

    localparam int SCW = cnt_width(SETTLE_CYCLES);
    localparam int HCW = cnt_width(COIN_HOLD);
    localparam int RCW = cnt_width(RST_DELAY);

    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_PLAYERS - 1);
    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [HCW-1:0]   HOLD_LAST   = HCW'(COIN_HOLD - 1);
    localparam logic [RCW-1:0]   RST_LAST    = RCW'(RST_DELAY - 1);

    logic [JOY_W-1:0]       joy_meta;
    logic [JOY_W-1:0]       sync_joy;
    logic [NUM_PLAYERS-1:0] coin_meta;
    logic [NUM_PLAYERS-1:0] sync_coin;
    logic [NUM_PLAYERS-1:0] coin_prev;
    logic [NUM_PLAYERS-1:0] coin_fall;
    logic [HCW-1:0]         hold_cnt [NUM_PLAYERS];
    logic [SCW-1:0]         settle_cnt;
    logic [RCW-1:0]         rst_cnt;
    scan_state_t            state;
    logic                   sample_en;

    // Two-flop synchronisers for the asynchronous bus and coin pins; idle high.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            joy_meta  <= '1;
            sync_joy  <= '1;
            coin_meta <= '1;
            sync_coin <= '1;
        end else begin
            joy_meta  <= jjoy;
            sync_joy  <= joy_meta;
            coin_meta <= jcoin_n;
            sync_coin <= coin_meta;
        end
    end

    // Scan FSM: settle after each select change, then one sample cycle.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            jselect    <= '0;
            scan_done  <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= SAMPLE;
                        scan_done <= (jselect == SEL_LAST);
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                        scan_done  <= 1'b0;
                    end
                end
                SAMPLE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    scan_done  <= 1'b0;
                    jselect    <= (jselect == SEL_LAST) ? '0 : jselect + SEL_W'(1);
                end
                default: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    jselect    <= '0;
                    scan_done  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_en = (state == SAMPLE);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar b = 0; b < JOY_W; b++) begin : g_bit
            jamma_debounce_bit #(
                .DEB_COUNT (DEB_COUNT)
            ) u_deb (
                .clk    (pclk),
                .rst_n  (reset_n),
                .en     (sample_en && (jselect == SEL_W'(p))),
                .sample (sync_joy[b]),
                .out_n  (joy_n[p*JOY_W + b])
            );
        end
    end

    assign coin_fall = coin_prev & ~sync_coin;

    // Coin stretch: a falling edge starts (or restarts) a minimum low period.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            coin_prev <= '1;
            coin_n    <= '1;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                hold_cnt[p] <= '0;
            end
        end else begin
            coin_prev <= sync_coin;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (coin_fall[p]) begin
                    coin_n[p]   <= 1'b0;
                    hold_cnt[p] <= HOLD_LAST;
                end else if (!coin_n[p]) begin
                    if (hold_cnt[p] != '0) begin
                        hold_cnt[p] <= hold_cnt[p] - HCW'(1);
                    end else if (sync_coin[p]) begin
                        coin_n[p] <= 1'b1;
                    end
                end
            end
        end
    end

    // Core reset delay: held high for RST_DELAY cycles after release.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt    <= '0;
            core_reset <= 1'b1;
        end else if (core_reset) begin
            if (rst_cnt == RST_LAST) begin
                core_reset <= 1'b0;
            end else begin
                rst_cnt <= rst_cnt + RCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner: three instances (2 players
// DEB_COUNT=2, 2 players DEB_COUNT=1, 4 players DEB_COUNT=2), a random run
// against a slot-timing reference model, table vectors and corner sequences.
module tb_jamma_input_scanner;

    localparam int SETTLE = 4;
    localparam int SLOT   = SETTLE + 1;
    localparam int A_DEB  = 2;
    localparam int N_RAND = 300;

    logic        pclk;
    logic        reset_n;
    logic        use_mux;
    logic [7:0]  rnd_joy;
    logic [7:0]  pad [4];
    logic [7:0]  jjoy_a, jjoy_b, jjoy_c;
    logic [1:0]  jcoin_a, jcoin_b;
    logic [3:0]  jcoin_c;

    logic [0:0]  jselect_a, jselect_b;
    logic [1:0]  jselect_c;
    logic [15:0] joy_n_a, joy_n_b;
    logic [31:0] joy_n_c;
    logic [1:0]  coin_n_a, coin_n_b;
    logic [3:0]  coin_n_c;
    logic        scan_done_a, scan_done_b, scan_done_c;
    logic        core_reset_a, core_reset_b, core_reset_c;

    int checks;
    int errors;

    // External player-select multiplexer on the board.
    assign jjoy_a = use_mux ? pad[jselect_a] : rnd_joy;
    assign jjoy_b = pad[jselect_b];
    assign jjoy_c = pad[jselect_c];

    jamma_input_scanner #(
        .NUM_PLAYERS(2), .JOY_W(8), .SETTLE_CYCLES(SETTLE), .DEB_COUNT(A_DEB),
        .COIN_HOLD(8), .RST_DELAY(16)
    ) dut_a (
        .pclk(pclk), .reset_n(reset_n), .jjoy(jjoy_a), .jcoin_n(jcoin_a),
        .jselect(jselect_a), .joy_n(joy_n_a), .coin_n(coin_n_a),
        .scan_done(scan_done_a), .core_reset(core_reset_a)
    );

    jamma_input_scanner #(
        .NUM_PLAYERS(2), .JOY_W(8), .SETTLE_CYCLES(SETTLE), .DEB_COUNT(1),
        .COIN_HOLD(8), .RST_DELAY(16)
    ) dut_b (
        .pclk(pclk), .reset_n(reset_n), .jjoy(jjoy_b), .jcoin_n(jcoin_b),
        .jselect(jselect_b), .joy_n(joy_n_b), .coin_n(coin_n_b),
        .scan_done(scan_done_b), .core_reset(core_reset_b)
    );

    jamma_input_scanner #(
        .NUM_PLAYERS(4), .JOY_W(8), .SETTLE_CYCLES(SETTLE), .DEB_COUNT(2),
        .COIN_HOLD(8), .RST_DELAY(16)
    ) dut_c (
        .pclk(pclk), .reset_n(reset_n), .jjoy(jjoy_c), .jcoin_n(jcoin_c),
        .jselect(jselect_c), .joy_n(joy_n_c), .coin_n(coin_n_c),
        .scan_done(scan_done_c), .core_reset(core_reset_c)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        int          scans;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [10];

    // Reference model state for dut_a in the random run.
    logic [7:0] mj [2];
    int         streak [2][8];
    logic [7:0] hist [0:N_RAND];
    logic [7:0] smp;
    int         player;
    int         hold;

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        use_mux = 1'b0;
        rnd_joy = 8'hFF;
        for (int i = 0; i < 4; i++) pad[i] = 8'hFF;
        jcoin_a = 2'b11;
        jcoin_b = 2'b11;
        jcoin_c = 4'hF;

        //         p0     p1     scans  exp_a     exp_b
        vecs[0] = '{8'hFE, 8'hFF, 1, 16'hFFFF, 16'hFFFE};
        vecs[1] = '{8'hFE, 8'hFF, 1, 16'hFFFE, 16'hFFFE};
        vecs[2] = '{8'hFF, 8'h7F, 2, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{8'hFE, 8'h7F, 1, 16'h7FFF, 16'h7FFE};
        vecs[4] = '{8'hFF, 8'h7F, 1, 16'h7FFF, 16'h7FFF};
        vecs[5] = '{8'hFE, 8'h7F, 1, 16'h7FFF, 16'h7FFE};
        vecs[6] = '{8'hA5, 8'h5A, 2, 16'h5AA5, 16'h5AA5};
        vecs[7] = '{8'h00, 8'hFF, 1, 16'h5AA5, 16'hFF00};
        vecs[8] = '{8'h00, 8'hFF, 1, 16'hFF00, 16'hFF00};
        vecs[9] = '{8'hFE, 8'hFF, 2, 16'hFFFE, 16'hFFFE};

        // ---- reset values ----
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_jselect",   jselect_a, 1'b0);
        check("rst_joy_n",     joy_n_a, 16'hFFFF);
        check("rst_joy_n_c",   joy_n_c, 32'hFFFF_FFFF);
        check("rst_coin_n",    coin_n_a, 2'b11);
        check("rst_scan_done", scan_done_a, 1'b0);
        check("rst_core_rst",  core_reset_a, 1'b1);

        // ---- random run against the slot-timing model ----
        @(posedge pclk);
        #1 reset_n = 1'b1;
        mj[0] = 8'hFF;
        mj[1] = 8'hFF;
        for (int p = 0; p < 2; p++) for (int b = 0; b < 8; b++) streak[p][b] = 0;
        hold = 0;
        for (int n = 1; n <= N_RAND; n++) begin
            if (hold == 0) begin
                rnd_joy = 8'($urandom);
                hold = $urandom_range(1, 20);
            end
            hold--;
            hist[n] = rnd_joy;
            @(posedge pclk);
            // Sample of the slot that just ended, seen through two sync stages.
            if (n % SLOT == 0) begin
                player = ((n - 1) / SLOT) % 2;
                smp = hist[n - 2];
                for (int b = 0; b < 8; b++) begin
                    if (smp[b] != mj[player][b]) begin
                        streak[player][b]++;
                        if (streak[player][b] == A_DEB) begin
                            mj[player][b] = smp[b];
                            streak[player][b] = 0;
                        end
                    end else begin
                        streak[player][b] = 0;
                    end
                end
            end
            @(negedge pclk);
            check("rand_jselect", jselect_a, 64'((n / SLOT) % 2));
            check("rand_scan_done", scan_done_a,
                  64'((n % SLOT == SLOT - 1) && ((n / SLOT) % 2 == 1)));
            check("rand_core_reset", core_reset_a, 64'(n < 16));
            check("rand_joy_n", joy_n_a, {48'd0, mj[1], mj[0]});
        end

        // ---- table vectors through the board multiplexer ----
        reset_n = 1'b0;
        use_mux = 1'b1;
        repeat (2) @(posedge pclk);
        #1 reset_n = 1'b1;
        for (int v = 0; v < 10; v++) begin
            pad[0] = vecs[v].p0;
            pad[1] = vecs[v].p1;
            repeat (vecs[v].scans * 2 * SLOT) @(posedge pclk);
            @(negedge pclk);
            check($sformatf("vec%0d_deb2", v), joy_n_a, vecs[v].exp_a);
            check($sformatf("vec%0d_deb1", v), joy_n_b, vecs[v].exp_b);
        end

        // ---- reset asserted mid-SETTLE of player 1 ----
        repeat (7) @(posedge pclk);
        #1;
        check("pre_rst_jselect", jselect_a, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_jselect",   jselect_a, 1'b0);
        check("midrst_joy_n",     joy_n_a, 16'hFFFF);
        check("midrst_joy_n_b",   joy_n_b, 16'hFFFF);
        check("midrst_coin_n",    coin_n_a, 2'b11);
        check("midrst_scan_done", scan_done_a, 1'b0);
        check("midrst_core_rst",  core_reset_a, 1'b1);

        // ---- four-player sequence and word isolation ----
        pad[0] = 8'hEE;
        pad[1] = 8'hDD;
        pad[2] = 8'hBB;
        pad[3] = 8'h77;
        repeat (2) @(posedge pclk);
        #1 reset_n = 1'b1;
        check("np4_jselect_0", jselect_c, 2'd0);
        for (int n = 1; n <= 8 * SLOT; n++) begin
            @(posedge pclk);
            @(negedge pclk);
            if (n % SLOT == 0 && n <= 4 * SLOT)
                check($sformatf("np4_jselect_%0d", n), jselect_c, 64'((n / SLOT) % 4));
        end
        check("np4_joy_n",  joy_n_c, 32'h77BB_DDEE);
        check("np2_joy_n",  joy_n_a, 16'hDDEE);
        check("deb1_joy_n", joy_n_b, 16'hDDEE);

        // ---- coin pulse of two cycles stretched to eight ----
        @(posedge pclk);
        #1 jcoin_a[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge pclk);
            #1;
            if (k == 2) jcoin_a[1] = 1'b1;
            @(negedge pclk);
            check($sformatf("coin1_k%0d", k), coin_n_a[1], 64'(!(k >= 3 && k <= 10)));
            check($sformatf("coin0_k%0d", k), coin_n_a[0], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
